// File: rtl/tpu_instr_buffer.sv
// tpu_instr_buffer: show-ahead instruction FIFO with early-full, drain and commit sequencing.
// Optional sticky overflow/underflow flag O_Err under TPU_IBUF_ERR_CHK_EN.
module tpu_instr_buffer #(
  parameter int DEPTH       = 16,
  parameter int INSTR_W     = 64,
  parameter int ID_W        = 8,
  parameter int ISSUE_W     = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_We,
  input  logic [ID_W-1:0]            I_ThreadID,
  input  logic [INSTR_W-1:0]         I_Instr,
  input  logic                       I_Term,
  input  logic [ISSUE_W-1:0]         I_IssueNo,
  input  logic                       I_Flush,
  input  logic                       I_Rd,
  output logic                       O_Full,
  output logic                       O_Valid,
  output logic [ID_W-1:0]            O_ThreadID,
  output logic [INSTR_W-1:0]         O_Instr,
  output logic [$clog2(DEPTH):0]     O_Count,
  output logic                       O_Commit,
`ifdef TPU_IBUF_ERR_CHK_EN
  output logic                       O_Err,
`endif
  output logic [ISSUE_W-1:0]         O_IssueNo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH - FULL_MARGIN);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, COMMIT} state_t;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ID_W-1:0]    id_mem    [DEPTH];
  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic [ISSUE_W-1:0] issue_q, issue_d;
  logic               open, wr, rd;
  always_comb begin
    open     = (state_q == IDLE) || (state_q == FILL);
    wr       = I_We && !I_Flush && open && (count_q != DEPTH_C);
    rd       = I_Rd && !I_Flush && (count_q != '0);
    wr_ptr_d = I_Flush ? '0 : wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = I_Flush ? '0 : rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = I_Flush ? '0 : (wr && !rd) ? count_q + 1'b1 : (rd && !wr) ? count_q - 1'b1 : count_q;
    full_d   = count_d >= FULL_C;
    issue_d  = (!I_Flush && I_Term && open) ? I_IssueNo : issue_q;
    // A term with anything buffered (or arriving this cycle) must drain before committing
    state_d  = I_Flush                 ? IDLE :
               (state_q == COMMIT)     ? IDLE :
               (state_q == DRAIN)      ? ((count_d == '0) ? COMMIT : DRAIN) :
               I_Term                  ? ((count_q != '0 || wr) ? DRAIN : COMMIT) :
               wr                      ? FILL : state_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      issue_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      issue_q  <= issue_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset && wr) begin
      instr_mem[wr_ptr_q] <= I_Instr;
      id_mem[wr_ptr_q]    <= I_ThreadID;
    end
  end
`ifdef TPU_IBUF_ERR_CHK_EN
  logic err_q, err_d;
  always_comb err_d = err_q || (I_We && count_q == DEPTH_C) || (I_Rd && count_q == '0);
  always_ff @(posedge clock) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign O_Err = err_q;
`endif
  assign O_Valid    = count_q != '0;
  assign O_ThreadID = O_Valid ? id_mem[rd_ptr_q] : '0;
  assign O_Instr    = O_Valid ? instr_mem[rd_ptr_q] : '0;
  assign O_Count    = count_q;
  assign O_Full     = full_q;
  assign O_Commit   = state_q == COMMIT;
  assign O_IssueNo  = issue_q;
endmodule

// File: tb/tb_tpu_instr_buffer.sv
// tb_tpu_instr_buffer: directed table-driven bench for tpu_instr_buffer (default parameters).
module tb_tpu_instr_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        i_we, i_term, i_flush, i_rd;
  logic [7:0]  i_id, i_iss;
  logic [63:0] i_instr;
  logic        o_full, o_valid, o_commit;
  logic [7:0]  o_id, o_iss;
  logic [63:0] o_instr;
  logic [4:0]  o_count;
`ifdef TPU_IBUF_ERR_CHK_EN
  logic        o_err;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  tpu_instr_buffer dut (
    .clock(clock), .reset(reset), .I_We(i_we), .I_ThreadID(i_id), .I_Instr(i_instr),
    .I_Term(i_term), .I_IssueNo(i_iss), .I_Flush(i_flush), .I_Rd(i_rd),
    .O_Full(o_full), .O_Valid(o_valid), .O_ThreadID(o_id), .O_Instr(o_instr),
    .O_Count(o_count), .O_Commit(o_commit),
`ifdef TPU_IBUF_ERR_CHK_EN
    .O_Err(o_err),
`endif
    .O_IssueNo(o_iss));

  always #5 clock = ~clock;

  typedef struct packed {
    logic we; logic [7:0] id; logic term; logic [7:0] iss; logic rd;
    logic [4:0] cnt; logic val; logic [7:0] hid; logic full; logic com; logic [7:0] eiss;
  } vec_t;
  vec_t tbl [14];

  function automatic logic [63:0] instr_of(input logic [7:0] id);
    return {id, 48'h0123_4567_89AB, ~id};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] id, input logic term,
                      input logic [7:0] iss, input logic flush, input logic rd);
    i_we = we; i_id = id; i_instr = instr_of(id); i_term = term;
    i_iss = iss; i_flush = flush; i_rd = rd;
    @(posedge clock);
    #1;
    i_we = 0; i_term = 0; i_flush = 0; i_rd = 0;
  endtask

  task automatic chk_head(input string nm, input logic [4:0] cnt, input logic [7:0] hid);
    chk({nm, " count"}, 64'(o_count), 64'(cnt));
    chk({nm, " valid"}, 64'(o_valid), 64'(cnt != 0));
    chk({nm, " id"}, 64'(o_id), 64'(hid));
    chk({nm, " instr"}, o_instr, (cnt != 0) ? instr_of(hid) : 64'h0);
  endtask

  logic [7:0] q[$];

  initial begin
    i_we = 0; i_id = 0; i_instr = 0; i_term = 0; i_iss = 0; i_flush = 0; i_rd = 0;
    reset = 1'b0;
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 5'd2, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 5'd3, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h04, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h07};
    tbl[10] = '{1'b1, 8'h05, 1'b1, 8'h2A, 1'b0, 5'd1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h2A};
    tbl[11] = '{1'b1, 8'h06, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h2A};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h2A};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h2A};

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_head("reset", 5'd0, 8'h00);
    chk("reset full", 64'(o_full), 64'h0);
    chk("reset commit", 64'(o_commit), 64'h0);
    chk("reset issue", 64'(o_iss), 64'h0);
`ifdef TPU_IBUF_ERR_CHK_EN
    chk("reset err", 64'(o_err), 64'h0);
`endif
    reset = 1'b1;

    for (int r = 0; r < 14; r++) begin
      step(tbl[r].we, tbl[r].id, tbl[r].term, tbl[r].iss, 1'b0, tbl[r].rd);
      chk_head($sformatf("row%0d", r), tbl[r].cnt, tbl[r].hid);
      chk($sformatf("row%0d full", r), 64'(o_full), 64'(tbl[r].full));
      chk($sformatf("row%0d commit", r), 64'(o_commit), 64'(tbl[r].com));
      chk($sformatf("row%0d issue", r), 64'(o_iss), 64'(tbl[r].eiss));
    end
`ifdef TPU_IBUF_ERR_CHK_EN
    chk("underflow err", 64'(o_err), 64'h1);
`endif

    // Fresh reset, then fill to capacity and overflow
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
`ifdef TPU_IBUF_ERR_CHK_EN
    chk("rereset err", 64'(o_err), 64'h0);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(8'h10 + i), 0, 0, 0, 0);
      chk_head($sformatf("fill%0d", i), 5'(i + 1), 8'h10);
      chk($sformatf("fill%0d full", i), 64'(o_full), 64'(i + 1 >= 14));
    end
    step(1, 8'hEE, 0, 0, 0, 0);
    chk_head("overflow", 5'd16, 8'h10);
    chk("overflow full", 64'(o_full), 64'h1);
`ifdef TPU_IBUF_ERR_CHK_EN
    chk("overflow err", 64'(o_err), 64'h1);
`endif
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0, 0, 0, 1);
      chk_head($sformatf("empty%0d", k), 5'(16 - k), (k < 16) ? 8'(8'h10 + k) : 8'h00);
      chk($sformatf("empty%0d full", k), 64'(o_full), 64'(16 - k >= 14));
    end

    // Steady write+read at count 5 with pointer wrap
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(8'h40 + i), 0, 0, 0, 0);
      q.push_back(8'(8'h40 + i));
    end
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h50 + i), 0, 0, 0, 1);
      q.push_back(8'(8'h50 + i));
      void'(q.pop_front());
      chk_head($sformatf("stream%0d", i), 5'd5, q[0]);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1);
      void'(q.pop_front());
      chk_head($sformatf("tail%0d", i), 5'(4 - i), (i < 4) ? q[0] : 8'h00);
    end

    // Write 4, term, drain, commit one cycle after last pop
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    step(0, 0, 1, 8'h2A, 0, 0);
    chk("term commit", 64'(o_commit), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk($sformatf("drain%0d commit", i), 64'(o_commit), 64'(i == 3));
    end
    chk("drain issue", 64'(o_iss), 64'h2A);
    step(0, 0, 0, 0, 0, 0);
    chk("post commit", 64'(o_commit), 64'h0);
    step(1, 8'h6F, 0, 0, 0, 0);
    chk_head("idle accepts", 5'd1, 8'h6F);
    step(0, 0, 0, 0, 0, 1);

    // Write 6, term, pop 2, flush
    for (int i = 0; i < 6; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
    step(0, 0, 1, 8'h3C, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_head("prefl", 5'd4, 8'h82);
    step(0, 0, 0, 0, 1, 0);
    chk_head("flush", 5'd0, 8'h00);
    chk("flush commit", 64'(o_commit), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk($sformatf("postfl%0d commit", i), 64'(o_commit), 64'h0);
    end
    step(1, 8'h70, 0, 0, 0, 0);
    chk_head("postfl write", 5'd1, 8'h70);

    // Reset asserted mid-drain
    step(1, 8'h71, 0, 0, 0, 0);
    step(1, 8'h72, 0, 0, 0, 0);
    step(0, 0, 1, 8'h55, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk_head("predrain", 5'd2, 8'h71);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    chk_head("midreset", 5'd0, 8'h00);
    chk("midreset commit", 64'(o_commit), 64'h0);
    chk("midreset issue", 64'(o_iss), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk($sformatf("postrst%0d commit", i), 64'(o_commit), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
